// File: rtl/ddr2_cmd_driver.sv
// Host-side command driver: takes test patterns from a valid/ready source and
// injects them into the DDR2 controller input FIFO, honouring its flow control.
module ddr2_cmd_driver #(
   parameter int FIFO_DEPTH = 64,
   parameter int BURST_UNIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pat_valid,
   output logic        pat_ready,
   input  logic [2:0]  pat_cmd,
   input  logic [1:0]  pat_sz,
   input  logic [2:0]  pat_op,
   input  logic [24:0] pat_addr,
   input  logic [15:0] pat_data,
   input  logic        pat_last,
   input  logic        fetch_en,
   input  logic [6:0]  fillcount,
   input  logic        notfull,
   output logic [2:0]  cmd,
   output logic [1:0]  sz,
   output logic [2:0]  op,
   output logic [15:0] din,
   output logic [24:0] addr,
   output logic        fetching,
   output logic        injection_done
);

   localparam logic [2:0] CMD_NOP  = 3'b000;
   localparam logic [2:0] CMD_SRD  = 3'b001;
   localparam logic [2:0] CMD_BRD  = 3'b011;
   localparam logic [2:0] CMD_BWR  = 3'b100;
   localparam logic [2:0] CMD_ARD  = 3'b101;
   localparam logic [2:0] CMD_RSVD = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ISSUE,
      ST_BURST,
      ST_DONE
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [2:0]  hold_cmd;
   logic [1:0]  hold_sz;
   logic [2:0]  hold_op;
   logic [24:0] hold_addr;
   logic [15:0] hold_data;
   logic        hold_last;
   logic [7:0]  word_k;

   logic        accept;
   logic        is_read;
   logic        is_discard;
   logic        space_ok;
   logic [7:0]  burst_len;
   logic        burst_end;

   assign accept     = pat_valid & pat_ready;
   assign is_discard = (pat_cmd == CMD_NOP) || (pat_cmd == CMD_RSVD);
   assign is_read    = (hold_cmd == CMD_SRD) || (hold_cmd == CMD_BRD) || (hold_cmd == CMD_ARD);
   assign burst_len  = 8'(BURST_UNIT) * (8'(hold_sz) + 8'd1);
   assign burst_end  = (word_k == (burst_len - 8'd1));

   // A block write must find room for the whole burst up front, since the
   // data words that follow the header are not re-checked against notfull.
   always_comb begin
      space_ok = notfull;
      if (hold_cmd == CMD_BWR) begin
         space_ok = ({1'b0, fillcount} <= (8'(FIFO_DEPTH) - burst_len));
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (is_discard) begin
                  state_nxt = pat_last ? ST_DONE : ST_IDLE;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (space_ok) begin
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if ((hold_cmd == CMD_BWR) && (burst_len > 8'd1)) begin
               state_nxt = ST_BURST;
            end else begin
               state_nxt = hold_last ? ST_DONE : ST_IDLE;
            end
         end
         ST_BURST: begin
            if (accept && burst_end) begin
               state_nxt = hold_last ? ST_DONE : ST_IDLE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_DONE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Header beat capture; only non-discarded commands are worth holding.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_cmd  <= CMD_NOP;
         hold_sz   <= 2'd0;
         hold_op   <= 3'd0;
         hold_addr <= 25'd0;
         hold_data <= 16'd0;
         hold_last <= 1'b0;
      end else if ((state == ST_IDLE) && accept && !is_discard) begin
         hold_cmd  <= pat_cmd;
         hold_sz   <= pat_sz;
         hold_op   <= pat_op;
         hold_addr <= pat_addr;
         hold_data <= pat_data;
         hold_last <= pat_last;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word_k <= 8'd0;
      end else if (state == ST_ISSUE) begin
         word_k <= 8'd1;
      end else if ((state == ST_BURST) && accept) begin
         word_k <= word_k + 8'd1;
      end
   end

   // Controller-facing outputs: cmd drops to NOP on every cycle without an
   // entry, while the other fields simply keep their last driven value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd  <= CMD_NOP;
         sz   <= 2'd0;
         op   <= 3'd0;
         din  <= 16'd0;
         addr <= 25'd0;
      end else begin
         cmd <= CMD_NOP;
         if (state == ST_ISSUE) begin
            cmd  <= hold_cmd;
            sz   <= hold_sz;
            op   <= hold_op;
            addr <= hold_addr;
            din  <= is_read ? 16'd0 : hold_data;
         end else if ((state == ST_BURST) && accept) begin
            cmd  <= CMD_BWR;
            sz   <= hold_sz;
            op   <= hold_op;
            addr <= hold_addr + 25'(word_k);
            din  <= pat_data;
         end
      end
   end

   // Handshake and status flags, registered from the upcoming state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat_ready      <= 1'b0;
         fetching       <= 1'b0;
         injection_done <= 1'b0;
      end else begin
         pat_ready      <= (state_nxt == ST_IDLE) || (state_nxt == ST_BURST);
         fetching       <= fetch_en;
         injection_done <= injection_done | (state == ST_DONE);
      end
   end

endmodule

// File: tb/tb_ddr2_cmd_driver.sv
// Scoreboard bench for ddr2_cmd_driver: stimulus pushes expected FIFO entries,
// a negedge monitor pops and compares every entry the driver presents.
module tb_ddr2_cmd_driver;

   typedef struct packed {
      logic [2:0]  cmd;
      logic [1:0]  sz;
      logic [2:0]  op;
      logic [24:0] addr;
      logic [15:0] din;
   } entry_t;

   logic        clk;
   logic        reset;
   logic        pat_valid;
   logic        pat_ready;
   logic [2:0]  pat_cmd;
   logic [1:0]  pat_sz;
   logic [2:0]  pat_op;
   logic [24:0] pat_addr;
   logic [15:0] pat_data;
   logic        pat_last;
   logic        fetch_en;
   logic [6:0]  fillcount;
   logic        notfull;
   logic [2:0]  cmd;
   logic [1:0]  sz;
   logic [2:0]  op;
   logic [15:0] din;
   logic [24:0] addr;
   logic        fetching;
   logic        injection_done;

   int          compared;
   int          mismatched;
   entry_t      expQ[$];
   logic        fetchExp;
   entry_t      gotEntry;
   entry_t      wantEntry;

   ddr2_cmd_driver #(.FIFO_DEPTH(64), .BURST_UNIT(8)) dut (
      .clk(clk),
      .reset(reset),
      .pat_valid(pat_valid),
      .pat_ready(pat_ready),
      .pat_cmd(pat_cmd),
      .pat_sz(pat_sz),
      .pat_op(pat_op),
      .pat_addr(pat_addr),
      .pat_data(pat_data),
      .pat_last(pat_last),
      .fetch_en(fetch_en),
      .fillcount(fillcount),
      .notfull(notfull),
      .cmd(cmd),
      .sz(sz),
      .op(op),
      .din(din),
      .addr(addr),
      .fetching(fetching),
      .injection_done(injection_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Host fetch enable wanders randomly; fetching must trail it by one clock.
   initial begin
      fetch_en = 1'b0;
      forever begin
         @(posedge clk);
         #1 fetch_en = 1'($urandom_range(0, 1));
      end
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) fetchExp <= 1'b0;
      else        fetchExp <= fetch_en;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared = compared + 1;
      if (actual !== expected) begin
         mismatched = mismatched + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      checkOutput("fetching", 64'(fetching), 64'(fetchExp));
   end

   // Scoreboard monitor: every non-NOP cycle is one FIFO entry.
   always @(negedge clk) begin
      if (reset && (cmd != 3'b000)) begin
         gotEntry = '{cmd: cmd, sz: sz, op: op, addr: addr, din: din};
         if (expQ.size() == 0) begin
            compared   = compared + 1;
            mismatched = mismatched + 1;
            $display("[TB] FAIL unexpected-entry: got 0x%0h, expected none", gotEntry);
         end else begin
            wantEntry = expQ.pop_front();
            checkOutput("entry", 64'(gotEntry), 64'(wantEntry));
         end
      end
   end

   task automatic pushEntry(input logic [2:0] c, input logic [1:0] s, input logic [2:0] o,
                            input logic [24:0] a, input logic [15:0] d);
      expQ.push_back('{cmd: c, sz: s, op: o, addr: a, din: d});
   endtask

   // Present one beat and hold it until the driver accepts it; returns #1
   // after the accepting edge with pat_valid still high.
   task automatic applyStimulus(input logic [2:0] c, input logic [1:0] s, input logic [2:0] o,
                                input logic [24:0] a, input logic [15:0] d, input logic l);
      int waited;
      waited    = 0;
      pat_valid = 1'b1;
      pat_cmd   = c;
      pat_sz    = s;
      pat_op    = o;
      pat_addr  = a;
      pat_data  = d;
      pat_last  = l;
      do begin
         @(negedge clk);
         waited++;
      end while (!pat_ready && waited < 200);
      if (!pat_ready) begin
         compared   = compared + 1;
         mismatched = mismatched + 1;
         $display("[TB] FAIL handshake-timeout: pat_ready stayed 0, expected 1");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      pat_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int waited;
      compared   = 0;
      mismatched = 0;
      reset      = 1'b0;
      pat_valid  = 1'b0;
      pat_cmd    = 3'b000;
      pat_sz     = 2'd0;
      pat_op     = 3'd0;
      pat_addr   = 25'd0;
      pat_data   = 16'd0;
      pat_last   = 1'b0;
      fillcount  = 7'd0;
      notfull    = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst-cmd", 64'(cmd), 64'd0);
      checkOutput("rst-addr-din", 64'({addr, din, sz, op}), 64'd0);
      checkOutput("rst-ready", 64'(pat_ready), 64'd0);
      checkOutput("rst-done", 64'(injection_done), 64'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checkOutput("ready-before-edge", 64'(pat_ready), 64'd0);
      @(negedge clk);
      checkOutput("ready-after-release", 64'(pat_ready), 64'd1);
      checkOutput("idle-cmd", 64'(cmd), 64'd0);
      checkOutput("idle-done", 64'(injection_done), 64'd0);
      @(posedge clk);
      #1;

      // Scalar write: appears two edges after acceptance for one cycle
      pushEntry(3'b010, 2'd0, 3'd0, 25'h0000123, 16'hBEEF);
      applyStimulus(3'b010, 2'd0, 3'd0, 25'h0000123, 16'hBEEF, 1'b0);
      pat_valid = 1'b0;
      @(negedge clk);
      checkOutput("wr-lat-1", 64'(cmd), 64'd0);
      @(negedge clk);
      checkOutput("wr-lat-2", 64'(cmd), 64'd0);
      @(negedge clk);
      checkOutput("wr-issue", 64'(cmd), 64'(3'b010));
      @(negedge clk);
      checkOutput("wr-after", 64'(cmd), 64'd0);
      @(posedge clk);
      #1;

      // Block write wrapping the 25-bit address space, exactly enough room
      fillcount = 7'd56;
      for (int i = 0; i < 8; i++) begin
         pushEntry(3'b100, 2'd0, 3'd0, 25'h1FFFFFE + 25'(i), 16'(i + 1));
      end
      applyStimulus(3'b100, 2'd0, 3'd0, 25'h1FFFFFE, 16'h0001, 1'b0);
      for (int i = 1; i < 8; i++) begin
         applyStimulus(3'b111, 2'd3, 3'd7, 25'h0ABCDEF, 16'(i + 1), 1'b0);
      end
      idleCycles(4);
      checkOutput("bwr-drained", 64'(expQ.size()), 64'd0);

      // Block write one entry short of room: must stall in WAIT
      fillcount = 7'd57;
      for (int i = 0; i < 8; i++) begin
         pushEntry(3'b100, 2'd0, 3'd2, 25'h0000100 + 25'(i), 16'h0011 + 16'(i));
      end
      applyStimulus(3'b100, 2'd0, 3'd2, 25'h0000100, 16'h0011, 1'b0);
      pat_valid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         checkOutput("bwr-stall-cmd", 64'(cmd), 64'd0);
         checkOutput("bwr-stall-ready", 64'(pat_ready), 64'd0);
      end
      @(posedge clk);
      #1 fillcount = 7'd56;
      for (int i = 1; i < 8; i++) begin
         applyStimulus(3'b000, 2'd1, 3'd1, 25'h1555555, 16'h0011 + 16'(i), 1'b0);
      end
      idleCycles(4);
      checkOutput("bwr-stall-drained", 64'(expQ.size()), 64'd0);

      // Scalar read held off by notfull=0
      notfull = 1'b0;
      pushEntry(3'b001, 2'd0, 3'd0, 25'h0000ABC, 16'h0000);
      applyStimulus(3'b001, 2'd0, 3'd0, 25'h0000ABC, 16'h5555, 1'b0);
      pat_valid = 1'b0;
      repeat (10) begin
         @(negedge clk);
         checkOutput("rd-stall-cmd", 64'(cmd), 64'd0);
      end
      @(posedge clk);
      #1 notfull = 1'b1;
      idleCycles(5);
      checkOutput("rd-drained", 64'(expQ.size()), 64'd0);

      // Discarded NOP, then three patterns with the last flagged
      applyStimulus(3'b000, 2'd0, 3'd0, 25'h0000777, 16'h7777, 1'b0);
      pushEntry(3'b110, 2'd0, 3'd3, 25'h0000010, 16'hA5A5);
      applyStimulus(3'b110, 2'd0, 3'd3, 25'h0000010, 16'hA5A5, 1'b0);
      pushEntry(3'b011, 2'd2, 3'd0, 25'h0000200, 16'h0000);
      applyStimulus(3'b011, 2'd2, 3'd0, 25'h0000200, 16'h1234, 1'b0);
      pushEntry(3'b101, 2'd0, 3'd5, 25'h0000300, 16'h0000);
      applyStimulus(3'b101, 2'd0, 3'd5, 25'h0000300, 16'h4321, 1'b1);
      pat_valid = 1'b0;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (cmd != 3'b101 && waited < 20);
      checkOutput("last-entry-seen", 64'(cmd), 64'(3'b101));
      checkOutput("done-not-yet", 64'(injection_done), 64'd0);
      @(negedge clk);
      checkOutput("done-rise", 64'(injection_done), 64'd1);
      repeat (5) begin
         @(negedge clk);
         checkOutput("done-ready", 64'(pat_ready), 64'd0);
         checkOutput("done-cmd", 64'(cmd), 64'd0);
         checkOutput("done-held", 64'(injection_done), 64'd1);
      end

      checkOutput("queue-empty", 64'(expQ.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
